sprite_sdr_responder: RTL and testbench

- Responder end of the sprite-renderer SDRAM read channel.
- Accepts single-cycle 64-bit read requests (byte address plus request pulse) and issues them as 4-beat 16-bit bursts on the lower-level memory port.
- Assembles the beats into one 64-bit word and returns it with a one-cycle ready pulse.
- Also converts the renderer's refresh hints into refresh commands issued during idle slots.

---
 rtl/sdr_pkg.sv | 6 +
 rtl/sdr_beat_packer.sv | 32 +++
 rtl/sprite_sdr_responder.sv | 130 +++++++++++++
 tb/tb_sprite_sdr_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_pkg.sv
// sdr_pkg: shared state encoding and line geometry for the sprite SDRAM read channel
package sdr_pkg;
    typedef enum logic [2:0] {IDLE, READ, BURST, DONE, REFRESH} sdr_state_t;
    localparam int SDR_BEATS      = 4;
    localparam int SDR_LINE_BYTES = 8;
endpackage

// File: rtl/sdr_beat_packer.sv
// sdr_beat_packer: counts burst beats and assembles them into one line, first beat least significant
module sdr_beat_packer #(
    parameter int DW    = 16,
    parameter int BEATS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                valid,
    input  logic [DW-1:0]       din,
    output logic                last,
    output logic [DW*BEATS-1:0] dout
);
    localparam int CW = $clog2(BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    logic [CW-1:0]            cnt;
    logic [DW*(BEATS-1)-1:0]  sh;
    assign last = valid && cnt == LAST_BEAT;
    assign dout = {din, sh};
    // Shift each beat in from the top so the first beat ends up in the low bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            sh  <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (valid) begin
            cnt <= cnt + 1'b1;
            sh  <= {din, sh[DW*(BEATS-1)-1:DW]};
        end
    end
endmodule

// File: rtl/sprite_sdr_responder.sv
// sprite_sdr_responder: turns 64-bit renderer reads into 4-beat SDRAM bursts and idle-slot refreshes; SPRITE_SDR_CACHE_EN adds a one-line cache
module sprite_sdr_responder
    import sdr_pkg::*;
#(
    parameter int ADDR_W = 25,
    parameter int MEM_DW = 16,
    parameter int BEATS  = SDR_BEATS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sdr_req,
    input  logic [ADDR_W-1:0] sdr_addr,
    input  logic              sdr_refresh,
    output logic [63:0]       sdr_data,
    output logic              sdr_rdy,
    output logic              overrun,
    output logic              mem_req,
    output logic [ADDR_W-2:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_valid,
    input  logic [MEM_DW-1:0] mem_dout,
    output logic              mem_refresh,
    input  logic              mem_refresh_ack
);
    localparam int TAG_W = ADDR_W - $clog2(SDR_LINE_BYTES);
    sdr_state_t       state;
    logic             pend_v, ref_f, last, hit;
    logic [TAG_W-1:0] pend_t, req_t, next_t;
    logic [63:0]      line, hit_data;
    logic             free, go, direct;
    logic             unused_lsb;
    assign unused_lsb = ^sdr_addr[ADDR_W-TAG_W-1:0];
    assign req_t  = sdr_addr[ADDR_W-1:ADDR_W-TAG_W];
    assign free   = state == IDLE || state == DONE;
    assign go     = free && (pend_v || sdr_req);
    assign direct = free && !pend_v && sdr_req;
    assign next_t = pend_v ? pend_t : req_t;
    sdr_beat_packer #(.DW(MEM_DW), .BEATS(BEATS)) u_packer (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (state == READ && mem_ack),
        .valid   (state == BURST && mem_valid),
        .din     (mem_dout),
        .last    (last),
        .dout    (line)
    );
`ifdef SPRITE_SDR_CACHE_EN
    logic             c_v;
    logic [TAG_W-1:0] c_t;
    logic [63:0]      c_d;
    assign hit      = c_v && c_t == next_t;
    assign hit_data = c_d;
    // Remember the most recently fetched line so an immediate repeat skips memory
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_v <= 1'b0;
            c_t <= '0;
            c_d <= '0;
        end else if (state == BURST && last) begin
            c_v <= 1'b1;
            c_t <= mem_addr[ADDR_W-2:2];
            c_d <= line;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif
    // Dispatch reads ahead of refreshes, track the one-deep pending slot and the refresh hint
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            sdr_data    <= '0;
            sdr_rdy     <= 1'b0;
            overrun     <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_refresh <= 1'b0;
            pend_v      <= 1'b0;
            pend_t      <= '0;
            ref_f       <= 1'b0;
        end else begin
            sdr_rdy <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (go && hit) begin
                        sdr_data <= hit_data;
                        sdr_rdy  <= 1'b1;
                        state    <= DONE;
                    end else if (go) begin
                        mem_req  <= 1'b1;
                        mem_addr <= {next_t, 2'b00};
                        state    <= READ;
                    end else if (ref_f) begin
                        mem_refresh <= 1'b1;
                        state       <= REFRESH;
                    end else begin
                        state <= IDLE;
                    end
                end
                READ: if (mem_ack) begin
                    mem_req <= 1'b0;
                    state   <= BURST;
                end
                BURST: if (last) begin
                    sdr_data <= line;
                    sdr_rdy  <= 1'b1;
                    state    <= DONE;
                end
                REFRESH: if (mem_refresh_ack) begin
                    mem_refresh <= 1'b0;
                    ref_f       <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (sdr_req && !direct) begin
                if (pend_v && !free) begin
                    overrun <= 1'b1;
                end else begin
                    pend_v <= 1'b1;
                    pend_t <= req_t;
                end
            end else if (free) begin
                pend_v <= 1'b0;
            end
            if (state == IDLE && !pend_v && sdr_refresh) ref_f <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sprite_sdr_responder.sv
// tb_sprite_sdr_responder: table-driven cycle vectors plus directed reset, slow-ack and cache sequences
module tb_sprite_sdr_responder;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        sdr_req = 1'b0, sdr_refresh = 1'b0;
    logic [24:0] sdr_addr = '0;
    logic [63:0] sdr_data;
    logic        sdr_rdy, overrun, mem_req, mem_refresh;
    logic [23:0] mem_addr;
    logic        mem_ack = 1'b0, mem_valid = 1'b0, mem_refresh_ack = 1'b0;
    logic [15:0] mem_dout = '0;
    int          n_cmp = 0, n_bad = 0;

    typedef struct {
        logic        req;
        logic [24:0] addr;
        logic        ack, val;
        logic [15:0] dout;
        logic        refh, rack;
        logic        e_mreq;
        logic [23:0] e_maddr;
        logic        e_rdy, e_mref, e_ovr;
        logic [63:0] e_data;
    } vec_t;
    vec_t vq[$];

    sprite_sdr_responder dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sdr_req         (sdr_req),
        .sdr_addr        (sdr_addr),
        .sdr_refresh     (sdr_refresh),
        .sdr_data        (sdr_data),
        .sdr_rdy         (sdr_rdy),
        .overrun         (overrun),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_valid       (mem_valid),
        .mem_dout        (mem_dout),
        .mem_refresh     (mem_refresh),
        .mem_refresh_ack (mem_refresh_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic add(input logic req, input logic [24:0] addr, input logic ack, input logic val,
                       input logic [15:0] dout, input logic refh, input logic rack, input logic e_mreq,
                       input logic [23:0] e_maddr, input logic e_rdy, input logic e_mref,
                       input logic e_ovr, input logic [63:0] e_data);
        vec_t v;
        v.req = req; v.addr = addr; v.ack = ack; v.val = val; v.dout = dout;
        v.refh = refh; v.rack = rack; v.e_mreq = e_mreq; v.e_maddr = e_maddr;
        v.e_rdy = e_rdy; v.e_mref = e_mref; v.e_ovr = e_ovr; v.e_data = e_data;
        vq.push_back(v);
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_mreq"}, 64'(mem_req), 64'd0);
        chk({n, "_rdy"}, 64'(sdr_rdy), 64'd0);
        chk({n, "_mref"}, 64'(mem_refresh), 64'd0);
        chk({n, "_ovr"}, 64'(overrun), 64'd0);
        chk({n, "_data"}, sdr_data, 64'd0);
        chk({n, "_maddr"}, 64'(mem_addr), 64'd0);
    endtask

    task automatic read_seq(input logic [24:0] a, input logic [63:0] line, input int dly, input int gap);
        logic [23:0] ma;
        ma = {a[24:3], 2'b00};
        tick; sdr_req = 1'b1; sdr_addr = a;
        tick; sdr_req = 1'b0;
        for (int i = 0; i < dly; i++) begin
            chk("wait_mreq", 64'(mem_req), 64'd1);
            chk("wait_maddr", 64'(mem_addr), 64'(ma));
            tick;
        end
        mem_ack = 1'b1;
        chk("rd_mreq", 64'(mem_req), 64'd1);
        chk("rd_maddr", 64'(mem_addr), 64'(ma));
        tick; mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                chk("gap_rdy", 64'(sdr_rdy), 64'd0);
                chk("gap_mreq", 64'(mem_req), 64'd0);
                tick;
            end
            mem_valid = 1'b1; mem_dout = line[16*k +: 16];
            chk("beat_rdy", 64'(sdr_rdy), 64'd0);
            tick; mem_valid = 1'b0;
        end
        chk("rd_rdy", 64'(sdr_rdy), 64'd1);
        chk("rd_data", sdr_data, line);
        tick;
        chk("rd_rdy_low", 64'(sdr_rdy), 64'd0);
        chk("rd_data_hold", sdr_data, line);
    endtask

    initial begin
        add(1, 25'h100008, 0, 0, 16'h0,    0, 0, 0, 24'h0,      0, 0, 0, 64'h0);
        add(0, 25'h0,      1, 0, 16'h0,    0, 0, 1, 24'h080004, 0, 0, 0, 64'h0);
        add(0, 25'h0,      0, 1, 16'h1111, 0, 0, 0, 24'h0,      0, 0, 0, 64'h0);
        add(0, 25'h0,      0, 1, 16'h2222, 0, 0, 0, 24'h0,      0, 0, 0, 64'h0);
        add(0, 25'h0,      0, 1, 16'h3333, 0, 0, 0, 24'h0,      0, 0, 0, 64'h0);
        add(0, 25'h0,      0, 1, 16'h4444, 0, 0, 0, 24'h0,      0, 0, 0, 64'h0);
        add(0, 25'h0,      0, 0, 16'h0,    0, 0, 0, 24'h0,      1, 0, 0, 64'h4444_3333_2222_1111);
        add(0, 25'h0,      0, 0, 16'h0,    0, 0, 0, 24'h0,      0, 0, 0, 64'h4444_3333_2222_1111);
        add(1, 25'h000040, 0, 0, 16'h0,    0, 0, 0, 24'h0,      0, 0, 0, 64'h4444_3333_2222_1111);
        add(0, 25'h0,      1, 0, 16'h0,    0, 0, 1, 24'h000020, 0, 0, 0, 64'h4444_3333_2222_1111);
        add(1, 25'h000080, 0, 1, 16'haaaa, 0, 0, 0, 24'h0,      0, 0, 0, 64'h4444_3333_2222_1111);
        add(1, 25'h0000c0, 0, 1, 16'hbbbb, 0, 0, 0, 24'h0,      0, 0, 0, 64'h4444_3333_2222_1111);
        add(0, 25'h0,      0, 1, 16'hcccc, 0, 0, 0, 24'h0,      0, 0, 1, 64'h4444_3333_2222_1111);
        add(0, 25'h0,      0, 1, 16'hdddd, 0, 0, 0, 24'h0,      0, 0, 1, 64'h4444_3333_2222_1111);
        add(0, 25'h0,      0, 0, 16'h0,    0, 0, 0, 24'h0,      1, 0, 1, 64'hdddd_cccc_bbbb_aaaa);
        add(0, 25'h0,      1, 0, 16'h0,    0, 0, 1, 24'h000040, 0, 0, 1, 64'hdddd_cccc_bbbb_aaaa);
        add(0, 25'h0,      0, 1, 16'h0001, 0, 0, 0, 24'h0,      0, 0, 1, 64'hdddd_cccc_bbbb_aaaa);
        add(0, 25'h0,      0, 1, 16'h0002, 0, 0, 0, 24'h0,      0, 0, 1, 64'hdddd_cccc_bbbb_aaaa);
        add(0, 25'h0,      0, 1, 16'h0003, 0, 0, 0, 24'h0,      0, 0, 1, 64'hdddd_cccc_bbbb_aaaa);
        add(0, 25'h0,      0, 1, 16'h0004, 0, 0, 0, 24'h0,      0, 0, 1, 64'hdddd_cccc_bbbb_aaaa);
        add(0, 25'h0,      0, 0, 16'h0,    0, 0, 0, 24'h0,      1, 0, 1, 64'h0004_0003_0002_0001);
        add(0, 25'h0,      0, 0, 16'h0,    1, 0, 0, 24'h0,      0, 0, 1, 64'h0004_0003_0002_0001);
        add(0, 25'h0,      0, 0, 16'h0,    0, 0, 0, 24'h0,      0, 0, 1, 64'h0004_0003_0002_0001);
        add(0, 25'h0,      0, 0, 16'h0,    0, 0, 0, 24'h0,      0, 1, 1, 64'h0004_0003_0002_0001);
        add(0, 25'h0,      0, 0, 16'h0,    0, 1, 0, 24'h0,      0, 1, 1, 64'h0004_0003_0002_0001);
        add(0, 25'h0,      0, 0, 16'h0,    0, 0, 0, 24'h0,      0, 0, 1, 64'h0004_0003_0002_0001);
        add(1, 25'h100008, 0, 0, 16'h0,    1, 0, 0, 24'h0,      0, 0, 1, 64'h0004_0003_0002_0001);
        add(0, 25'h0,      1, 0, 16'h0,    0, 0, 1, 24'h080004, 0, 0, 1, 64'h0004_0003_0002_0001);
        add(0, 25'h0,      0, 1, 16'h1234, 0, 0, 0, 24'h0,      0, 0, 1, 64'h0004_0003_0002_0001);
        add(0, 25'h0,      0, 1, 16'h5678, 0, 0, 0, 24'h0,      0, 0, 1, 64'h0004_0003_0002_0001);
        add(0, 25'h0,      0, 1, 16'h9abc, 0, 0, 0, 24'h0,      0, 0, 1, 64'h0004_0003_0002_0001);
        add(0, 25'h0,      0, 1, 16'hdef0, 0, 0, 0, 24'h0,      0, 0, 1, 64'h0004_0003_0002_0001);
        add(0, 25'h0,      0, 0, 16'h0,    0, 0, 0, 24'h0,      1, 0, 1, 64'hdef0_9abc_5678_1234);
        add(0, 25'h0,      0, 0, 16'h0,    0, 1, 0, 24'h0,      0, 1, 1, 64'hdef0_9abc_5678_1234);
        add(0, 25'h0,      0, 0, 16'h0,    0, 0, 0, 24'h0,      0, 0, 1, 64'hdef0_9abc_5678_1234);

        repeat (3) tick;
        chk_zero("reset");
        reset_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            tick;
            sdr_req = vq[i].req; sdr_addr = vq[i].addr; mem_ack = vq[i].ack;
            mem_valid = vq[i].val; mem_dout = vq[i].dout;
            sdr_refresh = vq[i].refh; mem_refresh_ack = vq[i].rack;
            chk($sformatf("v%0d_mreq", i), 64'(mem_req), 64'(vq[i].e_mreq));
            chk($sformatf("v%0d_rdy", i), 64'(sdr_rdy), 64'(vq[i].e_rdy));
            chk($sformatf("v%0d_mref", i), 64'(mem_refresh), 64'(vq[i].e_mref));
            chk($sformatf("v%0d_ovr", i), 64'(overrun), 64'(vq[i].e_ovr));
            chk($sformatf("v%0d_data", i), sdr_data, vq[i].e_data);
            if (vq[i].e_mreq) chk($sformatf("v%0d_maddr", i), 64'(mem_addr), 64'(vq[i].e_maddr));
        end
        tick;
        sdr_req = 1'b0; mem_ack = 1'b0; mem_valid = 1'b0; sdr_refresh = 1'b0; mem_refresh_ack = 1'b0;

        // reset in the middle of a burst, then stray beats
        tick; sdr_req = 1'b1; sdr_addr = 25'h100008;
        tick; sdr_req = 1'b0; mem_ack = 1'b1;
        chk("mb_mreq", 64'(mem_req), 64'd1);
        tick; mem_ack = 1'b0; mem_valid = 1'b1; mem_dout = 16'h5555;
        tick; mem_dout = 16'h6666;
        tick; mem_valid = 1'b0; reset_n = 1'b0;
        #1;
        chk_zero("mb_reset");
        tick; tick; reset_n = 1'b1;
        tick; mem_valid = 1'b1; mem_dout = 16'h7777;
        chk("stray_rdy0", 64'(sdr_rdy), 64'd0);
        tick; mem_dout = 16'h8888;
        chk("stray_rdy1", 64'(sdr_rdy), 64'd0);
        tick; mem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_zero($sformatf("stray%0d", i));
            tick;
        end
        read_seq(25'h100010, 64'h0123_4567_89ab_cdef, 0, 0);

        // slow acknowledge and gaps between beats
        read_seq(25'h000100, 64'hfeed_beef_cafe_f00d, 5, 2);

        // repeated line: cached when enabled, fetched again otherwise
        read_seq(25'h100008, 64'h1111_2222_3333_4444, 0, 0);
        tick; sdr_req = 1'b1; sdr_addr = 25'h100008;
        tick; sdr_req = 1'b0;
`ifdef SPRITE_SDR_CACHE_EN
        chk("hit_rdy", 64'(sdr_rdy), 64'd1);
        chk("hit_mreq", 64'(mem_req), 64'd0);
        chk("hit_data", sdr_data, 64'h1111_2222_3333_4444);
        tick;
        chk("hit_rdy_low", 64'(sdr_rdy), 64'd0);
`else
        chk("rep_rdy", 64'(sdr_rdy), 64'd0);
        chk("rep_mreq", 64'(mem_req), 64'd1);
        chk("rep_maddr", 64'(mem_addr), 64'h080004);
        mem_ack = 1'b1;
        tick; mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_valid = 1'b1; mem_dout = 16'h9000 + 16'(k);
            tick;
        end
        mem_valid = 1'b0;
        chk("rep_rdy_done", 64'(sdr_rdy), 64'd1);
        chk("rep_data", sdr_data, 64'h9003_9002_9001_9000);
        tick;
`endif
        read_seq(25'h100010, 64'h5a5a_a5a5_0f0f_f0f0, 0, 0);
        chk("end_ovr", 64'(overrun), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
